// File: rtl/program_sequencer.sv
// program_sequencer: fetch/sequencing stage with PC, IR and hardware return stack
// Ports:
//   CLK, RST            clock and asynchronous active-high reset
//   RUN, STEP           free-run enable and single-step request (rising edge)
//   ROM_DATA, ROM_ADDR  program ROM word (combinational) and its address (= PC)
//   JUMP_ADDR           jump/call target
//   nPC_LD, nSK_EN, SP_D_nU  decoder controls, honoured only during EXEC
//   OP, LR, SR          IR fields for the decoder
//   EXEC_PH             high during EXEC
//   STK_ERR             sticky stack overflow/underflow flag
module program_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  input  logic              STEP,
  input  logic [10:0]       ROM_DATA,
  input  logic [ADDR_W-1:0] JUMP_ADDR,
  input  logic              nPC_LD,
  input  logic              nSK_EN,
  input  logic              SP_D_nU,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic [4:0]        OP,
  output logic [2:0]        LR,
  output logic [2:0]        SR,
  output logic              EXEC_PH,
  output logic              STK_ERR
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] DEPTH = SP_W'(STACK_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_inc, pc_nxt, top;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [10:0] ir;
  logic [SP_W-1:0] sp, sp_m1, sp_nxt;
  logic step_q, step_rise, exec, ret, call, empty, full, push, err;
  assign ROM_ADDR  = pc;
  assign OP        = ir[10:6];
  assign LR        = ir[5:3];
  assign SR        = ir[2:0];
  assign EXEC_PH   = exec;
  assign exec      = state == EXEC;
  assign step_rise = STEP & ~step_q;
  assign ret       = !nSK_EN && SP_D_nU;
  assign call      = !nSK_EN && !SP_D_nU;
  assign empty     = sp == '0;
  assign full      = sp == DEPTH;
  assign pc_inc    = pc + ADDR_W'(1);
  assign sp_m1     = sp - SP_W'(1);
  assign push      = exec && call && !full;
  assign err       = (ret && empty) || (call && full);
  // Return target is the entry below SP; a mux avoids index-width mismatches.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (sp_m1 == SP_W'(i)) top = stack[i];
  end
  // Stack operations take priority over a plain PC load; a full-stack call still jumps.
  always_comb begin
    pc_nxt = ret ? (empty ? pc_inc : top) : (call || !nPC_LD) ? JUMP_ADDR : pc_inc;
    sp_nxt = ret ? (empty ? sp : sp_m1) : (call && !full) ? sp + SP_W'(1) : sp;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE)  ? ((RUN || step_rise) ? FETCH : IDLE) :
                (state == FETCH) ? EXEC :
                RUN ? FETCH : IDLE;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      sp      <= '0;
      step_q  <= 1'b0;
      STK_ERR <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_q <= STEP;
      if (state == FETCH) ir <= ROM_DATA;
      if (exec) begin
        pc      <= pc_nxt;
        sp      <= sp_nxt;
        STK_ERR <= STK_ERR | err;
      end
    end
  end
  always_ff @(posedge CLK) begin
    for (int i = 0; i < STACK_DEPTH; i++)
      if (push && sp == SP_W'(i)) stack[i] <= pc_inc;
  end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: table-driven and scoreboarded bench for program_sequencer
module tb_program_sequencer;
  localparam logic [1:0] K_N = 2'd0, K_J = 2'd1, K_C = 2'd2, K_R = 2'd3;
  logic CLK, RST, RUN, STEP, nPC_LD, nSK_EN, SP_D_nU, EXEC_PH, STK_ERR;
  logic [10:0] ROM_DATA;
  logic [7:0] JUMP_ADDR, ROM_ADDR;
  logic [4:0] OP;
  logic [2:0] LR, SR;
  logic [10:0] rom_mem [256];
  int tests = 0, fails = 0;
  typedef struct {
    logic [1:0] kind;
    logic [7:0] ja;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       err;
  } vec_t;
  typedef struct {
    logic [7:0] pc;
    logic [2:0] sp;
    logic       err;
    int         idx;
  } exp_t;
  vec_t tbl [25];
  exp_t sb [$];
  program_sequencer dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .ROM_DATA(ROM_DATA),
    .JUMP_ADDR(JUMP_ADDR), .nPC_LD(nPC_LD), .nSK_EN(nSK_EN), .SP_D_nU(SP_D_nU),
    .ROM_ADDR(ROM_ADDR), .OP(OP), .LR(LR), .SR(SR), .EXEC_PH(EXEC_PH), .STK_ERR(STK_ERR)
  );
  assign ROM_DATA = rom_mem[ROM_ADDR];
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic idle_ctl();
    nPC_LD = 1'b1; nSK_EN = 1'b1; SP_D_nU = 1'b0; JUMP_ADDR = 8'h00;
  endtask
  task automatic wait_exec(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      ok = EXEC_PH;
    end
    if (!ok) chk({name, "_exec_timeout"}, 32'(ok), 32'd1);
  endtask
  task automatic do_reset(input logic run);
    RST = 1'b1; RUN = run; STEP = 1'b0; idle_ctl();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask
  initial begin
    logic [7:0] cur;
    logic [10:0] w;
    exp_t e;
    int n;
    logic [7:0] seq_a [6];
    logic seq_p [6];
    for (int i = 0; i < 256; i++) rom_mem[i] = 11'h000;
    rom_mem[8'h40] = 11'h5AB;
    rom_mem[8'h80] = 11'h123;
    rom_mem[8'h12] = 11'h7FF;
    rom_mem[8'h01] = 11'h3C5;
    tbl[0]  = '{K_N, 8'h00, 8'h01, 3'd0, 1'b0};
    tbl[1]  = '{K_N, 8'h00, 8'h02, 3'd0, 1'b0};
    tbl[2]  = '{K_N, 8'h00, 8'h03, 3'd0, 1'b0};
    tbl[3]  = '{K_J, 8'h05, 8'h05, 3'd0, 1'b0};
    tbl[4]  = '{K_J, 8'h40, 8'h40, 3'd0, 1'b0};
    tbl[5]  = '{K_J, 8'h10, 8'h10, 3'd0, 1'b0};
    tbl[6]  = '{K_C, 8'h80, 8'h80, 3'd1, 1'b0};
    tbl[7]  = '{K_N, 8'h00, 8'h81, 3'd1, 1'b0};
    tbl[8]  = '{K_J, 8'h85, 8'h85, 3'd1, 1'b0};
    tbl[9]  = '{K_R, 8'hEE, 8'h11, 3'd0, 1'b0};
    tbl[10] = '{K_C, 8'h20, 8'h20, 3'd1, 1'b0};
    tbl[11] = '{K_C, 8'h30, 8'h30, 3'd2, 1'b0};
    tbl[12] = '{K_C, 8'h50, 8'h50, 3'd3, 1'b0};
    tbl[13] = '{K_C, 8'h60, 8'h60, 3'd4, 1'b0};
    tbl[14] = '{K_C, 8'h70, 8'h70, 3'd4, 1'b1};
    tbl[15] = '{K_R, 8'hEE, 8'h51, 3'd3, 1'b1};
    tbl[16] = '{K_R, 8'hEE, 8'h31, 3'd2, 1'b1};
    tbl[17] = '{K_R, 8'hEE, 8'h21, 3'd1, 1'b1};
    tbl[18] = '{K_R, 8'hEE, 8'h12, 3'd0, 1'b1};
    tbl[19] = '{K_R, 8'hEE, 8'h13, 3'd0, 1'b1};
    tbl[20] = '{K_J, 8'hFF, 8'hFF, 3'd0, 1'b1};
    tbl[21] = '{K_C, 8'h30, 8'h30, 3'd1, 1'b1};
    tbl[22] = '{K_R, 8'hEE, 8'h00, 3'd0, 1'b1};
    tbl[23] = '{K_J, 8'hFF, 8'hFF, 3'd0, 1'b1};
    tbl[24] = '{K_N, 8'h00, 8'h00, 3'd0, 1'b1};
    seq_a = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02};
    seq_p = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    // Reset values and free-run cadence
    RST = 1'b1; RUN = 1'b1; STEP = 1'b0; idle_ctl();
    #1;
    chk("rst_addr", 32'(ROM_ADDR), 32'h0);
    chk("rst_op", 32'({OP, LR, SR}), 32'h0);
    chk("rst_ph", 32'(EXEC_PH), 32'h0);
    chk("rst_err", 32'(STK_ERR), 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk($sformatf("run_addr[%0d]", i), 32'(ROM_ADDR), 32'(seq_a[i]));
      chk($sformatf("run_ph[%0d]", i), 32'(EXEC_PH), 32'(seq_p[i]));
    end
    // Table-driven instruction stream; expectations queued when controls are driven
    do_reset(1'b1);
    cur = 8'h00;
    for (int i = 0; i < 25; i++) begin
      wait_exec($sformatf("tbl[%0d]", i));
      w = rom_mem[cur];
      chk($sformatf("addr[%0d]", i), 32'(ROM_ADDR), 32'(cur));
      chk($sformatf("ir[%0d]", i), 32'({OP, LR, SR}), 32'({w[10:6], w[5:3], w[2:0]}));
      nPC_LD    = tbl[i].kind == K_N;
      nSK_EN    = !(tbl[i].kind == K_C || tbl[i].kind == K_R);
      SP_D_nU   = tbl[i].kind == K_R;
      JUMP_ADDR = tbl[i].ja;
      sb.push_back('{tbl[i].pc, tbl[i].sp, tbl[i].err, i});
      @(negedge CLK);
      e = sb.pop_front();
      chk($sformatf("pc[%0d]", e.idx), 32'(ROM_ADDR), 32'(e.pc));
      chk($sformatf("sp[%0d]", e.idx), 32'(dut.sp), 32'(e.sp));
      chk($sformatf("err[%0d]", e.idx), 32'(STK_ERR), 32'(e.err));
      // Active controls during FETCH must be ignored
      nPC_LD = 1'b0; nSK_EN = 1'b0; SP_D_nU = 1'b1; JUMP_ADDR = 8'hFF;
      cur = tbl[i].pc;
    end
    chk("op_5ab", 32'(rom_mem[8'h40][10:6]), 32'h16);
    // Reset in the middle of an EXEC with a call pending
    do_reset(1'b1);
    wait_exec("pre_rst0");
    @(negedge CLK);
    wait_exec("pre_rst1");
    chk("pre_rst_addr", 32'(ROM_ADDR), 32'h1);
    chk("pre_rst_ir", 32'({OP, LR, SR}), 32'h3C5);
    nPC_LD = 1'b0; nSK_EN = 1'b0; SP_D_nU = 1'b0; JUMP_ADDR = 8'h99;
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(ROM_ADDR), 32'h0);
    chk("mid_rst_ir", 32'({OP, LR, SR}), 32'h0);
    chk("mid_rst_sp", 32'(dut.sp), 32'h0);
    chk("mid_rst_err", 32'(STK_ERR), 32'h0);
    RUN = 1'b0; idle_ctl();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("post_rst_idle[%0d]", i), 32'({EXEC_PH, ROM_ADDR}), 32'h0);
    end
    chk("post_rst_sp", 32'(dut.sp), 32'h0);
    // Single step: STEP held for 3 cycles runs exactly one instruction
    n = 0;
    STEP = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 2) STEP = 1'b0;
      if (EXEC_PH) n++;
    end
    chk("step1_count", 32'(n), 32'd1);
    chk("step1_addr", 32'(ROM_ADDR), 32'h1);
    n = 0;
    STEP = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      STEP = 1'b0;
      if (EXEC_PH) n++;
    end
    chk("step2_count", 32'(n), 32'd1);
    chk("step2_addr", 32'(ROM_ADDR), 32'h2);
    // RUN dropping in FETCH still completes the instruction, then idles
    RUN = 1'b1;
    @(negedge CLK);
    chk("runfall_fetch", 32'({EXEC_PH, ROM_ADDR}), 32'h002);
    RUN = 1'b0;
    @(negedge CLK);
    chk("runfall_exec", 32'(EXEC_PH), 32'h1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (EXEC_PH) n++;
    end
    chk("runfall_idle", 32'(n), 32'd0);
    chk("runfall_addr", 32'(ROM_ADDR), 32'h3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch/sequencing stage directly upstream of the instruction decoder.
- Holds the program counter (PC), instruction register (IR) and a hardware return stack, and presents ROM_ADDR to program ROM.
- Splits the latched word into OP/LR/SR for the decoder.
- Consumes the decoder's nPC_LD, nSK_EN and SP_D_nU to choose the next PC; RUN/STEP give free-run or single-step operation.

Parameters:
ADDR_W, 8, width of PC, ROM_ADDR, JUMP_ADDR and stack entries.
STACK_DEPTH, 4, number of return-stack entries (legal 1..16).

Ports:
CLK  input  1  system clock, all state on rising edge.
RST  input  1  asynchronous, active-high reset.
RUN  input  1  1 = free-run; 0 = halt after the current instruction.
STEP  input  1  single-step request; a 0->1 transition sampled on CLK starts one instruction.
ROM_DATA  input  11  program word at ROM_ADDR, combinational (valid same cycle).
JUMP_ADDR  input  ADDR_W  jump/call target from the JR register path.
nPC_LD  input  1  active-low PC load (from decoder).
nSK_EN  input  1  active-low stack operation enable (from decoder).
SP_D_nU  input  1  stack direction: 1 = pop (return), 0 = push (call).
ROM_ADDR  output  ADDR_W  equals PC.
OP  output  5  IR[10:6].
LR  output  3  IR[5:3].
SR  output  3  IR[2:0].
EXEC_PH  output  1  high during EXEC; qualifies decoder strobes downstream.
STK_ERR  output  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (async, RST=1):
  - PC=0, IR=0 (so OP/LR/SR=0), SP=0, state=IDLE, EXEC_PH=0, STK_ERR=0.
  - STEP edge-detect register cleared to 0.
  - Reset mid-instruction aborts it with no PC or stack update.
- States:
  - IDLE -> FETCH when RUN=1 or a STEP rising edge is detected; otherwise stay. PC and IR hold.
  - FETCH (1 cycle): IR <= ROM_DATA at ROM_ADDR=PC; -> EXEC.
  - EXEC (1 cycle): EXEC_PH=1; decoder inputs are taken from this cycle. On the exit edge, the PC update below is applied. Then -> FETCH if RUN=1, else -> IDLE.
- Latency: 2 cycles per instruction. OP/LR/SR change only on the FETCH->EXEC edge and are stable through EXEC.
- PC update at end of EXEC, first match wins:
  1. Return (nSK_EN=0, SP_D_nU=1):
     - SP>0: SP <= SP-1, PC <= stack[SP-1].
     - SP=0: underflow. PC <= PC+1, SP stays 0, STK_ERR <= 1.
  2. Call (nSK_EN=0, SP_D_nU=0):
     - SP<STACK_DEPTH: stack[SP] <= PC+1, SP <= SP+1, PC <= JUMP_ADDR.
     - SP=STACK_DEPTH: overflow. No push, SP holds, STK_ERR <= 1, PC <= JUMP_ADDR (jump still taken).
  3. nPC_LD=0: PC <= JUMP_ADDR.
  4. Otherwise: PC <= PC+1.
- Arithmetic: PC+1 is modulo 2^ADDR_W (PC = 2^ADDR_W-1 wraps to 0). A pushed PC+1 uses the same wrap.
- nPC_LD, nSK_EN and SP_D_nU are ignored outside EXEC.
- SP range is 0..STACK_DEPTH, stored in a ceil(log2(STACK_DEPTH+1))-bit register.
- STEP:
  - Edge-detect register updates every cycle.
  - An edge during FETCH/EXEC is dropped; no queuing.
  - Held-high STEP runs exactly one instruction.
- RUN:
  - RUN falling during FETCH: the instruction completes EXEC, then the block goes IDLE.
  - RUN=1 and a STEP edge together in IDLE: behaves as RUN.
- STK_ERR is cleared only by RST.

Test Plan:
- Reset, RUN=1, ROM all 0x000 with no jumps -> ROM_ADDR 0,0,1,1,2,2... (each value held 2 cycles); EXEC_PH toggles 0,1,0,1; STK_ERR=0.
- At PC=5 apply nPC_LD=0, JUMP_ADDR=0x40 during EXEC -> next FETCH at ROM_ADDR=0x40; ROM_DATA=0x5AB there gives OP=0x16, LR=5, SR=3 in EXEC.
- Call at PC=0x10 to 0x80, then return at PC=0x85 -> PC goes 0x80, then after the return 0x11. SP goes 0->1->0.
- Five consecutive calls with STACK_DEPTH=4 -> fifth call still jumps, STK_ERR=1, SP=4. Then four returns unwind correctly; a fifth return gives PC+1 with SP=0.
- RUN=0, pulse STEP high for 3 cycles -> exactly one FETCH+EXEC, PC 0->1, then IDLE. A second STEP edge advances PC to 2.
- Assert RST mid-EXEC while a call is pending -> PC=0, SP=0, IR=0 immediately; no push occurs; state=IDLE once RST deasserts with RUN=0.
